systolic_feeder: RTL and testbench

//  Upstream stage of systolic_4x4. Buffers one frame of 32 4-bit words from a valid/ready stream
//  (16 weight words, then 16 input words). Replays the frame to the array as two contiguous
//  16-cycle bursts on data_in/load_weights/load_inputs. Waits for the array's valid_out, then

---
 rtl/systolic_feeder.sv | 134 +++++++++++++
 tb/tb_systolic_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - frame buffer that replays weight/input bursts into systolic_4x4
// Accepts a 32-word frame, plays it as two back-to-back 16-cycle bursts, then waits for the array.
module systolic_feeder #(
    parameter int DATA_W  = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] data_in,
    output logic              load_weights,
    output logic              load_inputs,
    input  logic              array_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    localparam int DEPTH  = 2 * N * N;
    localparam int HALF   = N * N;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  W_FIRST   = '0;
    localparam logic [PTR_W-1:0]  W_LAST    = PTR_W'(HALF - 1);
    localparam logic [PTR_W-1:0]  I_FIRST   = PTR_W'(HALF);
    localparam logic [PTR_W-1:0]  I_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {FILL, LOAD_W, LOAD_I, WAIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fill_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                frame_full;

    assign s_ready    = (state == FILL || state == WAIT) && (fill_cnt < FULL);
    assign accept     = s_valid && s_ready;
    assign frame_full = (fill_cnt == FULL);
    assign busy       = (state != FILL);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // rd_ptr always names the word currently driven on data_in while a burst is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            wait_cnt     <= '0;
            data_in      <= '0;
            load_weights <= 1'b0;
            load_inputs  <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fill_cnt <= fill_cnt + 1'b1;
            end
            case (state)
                FILL: begin
                    if (frame_full || (accept && fill_cnt == FULL_M1)) begin
                        state        <= LOAD_W;
                        rd_ptr       <= W_FIRST;
                        load_weights <= 1'b1;
                        data_in      <= mem[W_FIRST];
                    end
                end
                LOAD_W: begin
                    if (rd_ptr == W_LAST) begin
                        state        <= LOAD_I;
                        load_weights <= 1'b0;
                        load_inputs  <= 1'b1;
                        rd_ptr       <= I_FIRST;
                        data_in      <= mem[I_FIRST];
                    end else begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        data_in <= mem[rd_ptr + 1'b1];
                    end
                end
                LOAD_I: begin
                    if (rd_ptr == I_LAST) begin
                        state       <= WAIT;
                        load_inputs <= 1'b0;
                        data_in     <= '0;
                        rd_ptr      <= '0;
                        wait_cnt    <= '0;
                        fill_cnt    <= '0;
                        wr_ptr      <= '0;
                    end else begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        data_in <= mem[rd_ptr + 1'b1];
                    end
                end
                WAIT: begin
                    // array_valid outranks an expiring timer on the same cycle
                    if (array_valid || wait_cnt == WAIT_LAST) begin
                        done     <= array_valid;
                        timeout  <= !array_valid;
                        wait_cnt <= '0;
                        if (frame_full) begin
                            state        <= LOAD_W;
                            rd_ptr       <= W_FIRST;
                            load_weights <= 1'b1;
                            data_in      <= mem[W_FIRST];
                        end else begin
                            state <= FILL;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized scoreboard bench for systolic_feeder
module tb_systolic_feeder;
    localparam int DW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          array_valid = 1'b0;
    logic          s_ready, load_weights, load_inputs, busy, done, timeout;
    logic [DW-1:0] data_in;

    systolic_feeder #(.DATA_W(DW), .N(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .data_in(data_in), .load_weights(load_weights), .load_inputs(load_inputs),
        .array_valid(array_valid), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          s_ready;
        logic          lw;
        logic          li;
        logic          busy;
        logic          done;
        logic          to;
        logic [DW-1:0] data;
    } rec_t;

    rec_t  exp_q[$];
    string tag_q[$];
    int    cyc_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cycle = 0;

    // Reference model: phase 0 = collecting, 1 = playing frame, 2 = awaiting array.
    int            m_phase = 0;
    int            m_idx = 0;
    int            m_wait = 0;
    logic [DW-1:0] m_words[$];
    logic [DW-1:0] m_frame[32];
    logic          m_done = 1'b0;
    logic          m_to = 1'b0;

    int    k_vpct = 0;
    int    k_avd = -1;
    int    k_spur = 0;
    bit    k_rand = 1'b0;
    string k_tag = "reset_state";
    int    seq_n = 0;
    bit    pending = 1'b0;

    function automatic rec_t model_out();
        rec_t r;
        r.s_ready = (m_phase != 1) && (m_words.size() < 32);
        r.lw      = (m_phase == 1) && (m_idx < 16);
        r.li      = (m_phase == 1) && (m_idx >= 16);
        r.busy    = (m_phase != 0);
        r.done    = m_done;
        r.to      = m_to;
        r.data    = (m_phase == 1) ? m_frame[m_idx] : '0;
        return r;
    endfunction

    function automatic void start_play();
        for (int i = 0; i < 32; i++) m_frame[i] = m_words[i];
        m_words.delete();
        m_phase = 1;
        m_idx   = 0;
    endfunction

    function automatic void model_step(input bit rst, input bit take, input logic [DW-1:0] d,
                                       input bit av);
        bit full_before;
        full_before = (m_words.size() == 32);
        m_done = 1'b0;
        m_to   = 1'b0;
        if (rst) begin
            m_words.delete();
            m_phase = 0;
            m_idx   = 0;
            m_wait  = 0;
            return;
        end
        if (take) m_words.push_back(d);
        case (m_phase)
            0: if (m_words.size() == 32) start_play();
            1: begin
                if (m_idx == 31) begin
                    m_phase = 2;
                    m_wait  = 0;
                end else begin
                    m_idx++;
                end
            end
            default: begin
                if (av) m_done = 1'b1;
                else if (m_wait == TO - 1) m_to = 1'b1;
                if (m_done || m_to) begin
                    if (full_before) start_play();
                    else m_phase = 0;
                end else begin
                    m_wait++;
                end
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] word_for(input int n);
        if (k_rand) return DW'($urandom);
        return DW'(n % 16);
    endfunction

    task automatic step(input bit rst);
        rec_t e;
        bit   take;
        e = model_out();
        exp_q.push_back(e);
        tag_q.push_back(k_tag);
        cyc_q.push_back(cycle);
        reset = rst;
        if (!pending) begin
            s_valid = (int'($urandom_range(99)) < k_vpct);
            s_data  = s_valid ? word_for(seq_n) : DW'($urandom);
        end
        array_valid = (m_phase == 2 && m_wait == k_avd) ||
                      (m_phase != 2 && int'($urandom_range(99)) < k_spur);
        take    = s_valid && e.s_ready && !rst;
        pending = s_valid && !take && !rst;
        if (take) seq_n++;
        model_step(rst, take, s_data, array_valid);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic run(input string tag, input int n, input int vpct, input int avd,
                       input int spur, input bit rnd);
        k_tag  = tag;
        k_vpct = vpct;
        k_avd  = avd;
        k_spur = spur;
        k_rand = rnd;
        repeat (n) step(1'b0);
    endtask

    // Monitor: the DUT presents a full output record every cycle; compare it away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                rec_t  e;
                rec_t  g;
                string t;
                int    c;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                c = cyc_q.pop_front();
                g.s_ready = s_ready;
                g.lw      = load_weights;
                g.li      = load_inputs;
                g.busy    = busy;
                g.done    = done;
                g.to      = timeout;
                g.data    = data_in;
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL %s cycle %0d: got rdy=%b lw=%b li=%b busy=%b done=%b to=%b data=%h, expected rdy=%b lw=%b li=%b busy=%b done=%b to=%b data=%h",
                             t, c, g.s_ready, g.lw, g.li, g.busy, g.done, g.to, g.data,
                             e.s_ready, e.lw, e.li, e.busy, e.done, e.to, e.data);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1);
        step(1'b1);

        run("stream_no_stall", 110, 100, 9, 0, 1'b0);
        run("stream_toggle", 150, 50, 9, 20, 1'b0);
        run("refill_in_wait", 160, 100, 60, 0, 1'b1);
        run("timeout_late_valid", 200, 60, -1, 30, 1'b1);

        k_tag  = "reset_mid_load_w";
        k_vpct = 100;
        k_avd  = 9;
        k_spur = 0;
        for (int i = 0; i < 200 && !(m_phase == 1 && m_idx == 7); i++) step(1'b0);
        tests++;
        if (!(m_phase == 1 && m_idx == 7)) begin
            fails++;
            $display("FAIL reset_mid_load_w: never reached load_w cycle 8 (phase=%0d idx=%0d), required phase=1 idx=7",
                     m_phase, m_idx);
        end
        step(1'b1);
        seq_n = 0;
        run("after_reset", 120, 100, 9, 0, 1'b0);

        for (int b = 0; b < 6; b++) begin
            run("soak", 200, int'($urandom_range(30, 100)), int'($urandom_range(0, 70)), 10, 1'b1);
        end

        k_vpct = 0;
        k_spur = 0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d records left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
